// File: rtl/cam_core.sv
// Small FIFO-replacement CAM: DEPTH entries of WIDTH bits, parallel search on data_in.
// Each entry is its own instance holding data, valid bit and comparator.

module cam_entry #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] key,
    output logic             hit
);
    logic [WIDTH-1:0] mem;
    logic             valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem   <= '0;
            valid <= 1'b0;
        end else if (wr) begin
            mem   <= wdata;
            valid <= 1'b1;
        end
    end

    assign hit = valid & (mem == key);
endmodule

module cam_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             wr_en,
    output logic [DEPTH-1:0] match
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic             en;
        logic [WIDTH-1:0] data;
    } wr_req_t;

    wr_req_t            req;
    logic [PTR_W-1:0]   wr_ptr;
    logic               wr_fire;
    logic [DEPTH-1:0]   slot_wr;

    assign req.en   = wr_en;
    assign req.data = data_in;

    // A key already present suppresses the write, so held wr_en stores once.
    assign wr_fire = req.en & ~(|match);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wr_ptr <= '0;
        else if (wr_fire)
            wr_ptr <= wr_ptr + 1'b1;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign slot_wr[i] = wr_fire & (wr_ptr == PTR_W'(i));

        cam_entry #(.WIDTH(WIDTH)) u_entry (
            .clk   (clk),
            .rst   (rst),
            .wr    (slot_wr[i]),
            .wdata (req.data),
            .key   (data_in),
            .hit   (match[i])
        );
    end
endmodule

// File: tb/tb_cam_core.sv
// Directed bench for cam_core: reset, fill, duplicate suppression, wrap, same-cycle write, async reset.
module tb_cam_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data_in = 8'hAB;
    logic        wr_en = 1'b0;
    logic [15:0] match;

    int n_chk = 0;
    int n_err = 0;

    cam_core #(.WIDTH(8), .DEPTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .wr_en   (wr_en),
        .match   (match)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr1(input logic [7:0] d);
        data_in = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic srch(input string tag, input logic [7:0] d, input logic [15:0] exp);
        data_in = d;
        #1;
        chk(tag, match, exp);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        // 1 reset
        #2;
        chk("rst_held", match, 16'h0000);
        tick();
        rst = 1'b0;
        data_in = 8'h00;
        tick();
        chk("rst_zero_key", match, 16'h0000);

        // 2 fill with each write held two cycles
        data_in = 8'h3F; wr_en = 1'b1; tick(); tick();
        data_in = 8'h7A; tick(); tick();
        data_in = 8'hC3; tick(); tick();
        data_in = 8'h4B; tick(); tick();
        wr_en = 1'b0;
        srch("fill_3F", 8'h3F, 16'h0001);
        srch("fill_7A", 8'h7A, 16'h0002);
        srch("fill_C3", 8'hC3, 16'h0004);
        srch("fill_4B", 8'h4B, 16'h0008);
        srch("fill_AA", 8'hAA, 16'h0000);

        // wr_en low holds contents
        data_in = 8'h99; tick(); tick();
        srch("idle_99", 8'h99, 16'h0000);

        // 3 duplicate then fresh write
        wr1(8'h3F);
        wr1(8'h11);
        srch("dup_11", 8'h11, 16'h0010);
        srch("dup_3F", 8'h3F, 16'h0001);

        // 4 wrap
        do_reset();
        for (int i = 0; i <= 16; i++) wr1(8'(i));
        srch("wrap_00", 8'h00, 16'h0000);
        srch("wrap_10", 8'h10, 16'h0001);
        srch("wrap_0F", 8'h0F, 16'h8000);
        srch("wrap_01", 8'h01, 16'h0002);

        // 5 same-cycle write/search, wr_ptr is 1 here
        data_in = 8'h5A; wr_en = 1'b1;
        #1;
        chk("same_before", match, 16'h0000);
        tick();
        wr_en = 1'b0;
        chk("same_after", match, 16'h0002);
        srch("same_old01", 8'h01, 16'h0000);

        // 6 async reset between edges
        srch("pre_async", 8'h5A, 16'h0002);
        #2;
        rst = 1'b1;
        #1;
        chk("async_drop", match, 16'h0000);
        #1;
        rst = 1'b0;
        tick();
        wr1(8'h77);
        srch("post_rst_slot0", 8'h77, 16'h0001);
        srch("post_rst_5A", 8'h5A, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
